// File: rtl/tb_rd_stream_memory_pkg.sv
// Shared types for the testbench-side stream source memory.
package tb_rd_stream_memory_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN,
    DONE
  } rd_stream_state_e;

endpackage

// File: rtl/tb_stream_fifo.sv
// Small output buffer with flush. Push-to-valid latency is 1 cycle; pop on out_vld & out_rdy.
// The producer reserves space before pushing, so there is no input ready.
module tb_stream_fifo #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush,
  input  logic                       in_vld,
  input  logic [Width-1:0]           in_dat,
  output logic                       out_vld,
  output logic [Width-1:0]           out_dat,
  input  logic                       out_rdy,
  output logic [$clog2(Depth+1)-1:0] count
);

  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntWidth = $clog2(Depth + 1);

  logic [Width-1:0]    store [Depth];
  logic [PtrWidth-1:0] wr_ptr;
  logic [PtrWidth-1:0] rd_ptr;
  logic                push;
  logic                pop;

  assign out_vld = (count != '0);
  assign out_dat = store[rd_ptr];
  assign push    = in_vld;
  assign pop     = out_vld && out_rdy;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(Depth - 1)) ? '0 : p + PtrWidth'(1);
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) store[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        store[wr_ptr] <= in_dat;
        wr_ptr        <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      unique case ({push, pop})
        2'b10:   count <= count + CntWidth'(1);
        2'b01:   count <= count - CntWidth'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/tb_rd_stream_memory.sv
// Preloadable source memory streaming [start, start+len) over valid/ready, optionally looping.
// First word valid 2 cycles after start is sampled; issue is credited against buffer space so ready stalls never drop data.
module tb_rd_stream_memory
  import tb_rd_stream_memory_pkg::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned MemDepth  = 1024,
  parameter int unsigned BufDepth  = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic                 ld_en_i,
  input  logic [AddrWidth-1:0] ld_addr_i,
  input  logic [DataWidth-1:0] ld_data_i,
  input  logic [AddrWidth-1:0] cfg_start_addr_i,
  input  logic [AddrWidth-1:0] cfg_num_words_i,
  input  logic                 cfg_loop_i,
  input  logic                 start_i,
  input  logic                 stop_i,
  output logic [AddrWidth-1:0] rd_acc_addr_o,
  output logic [DataWidth-1:0] rd_acc_data_o,
  output logic                 rd_acc_valid_o,
  input  logic                 rd_acc_ready_i,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int unsigned IdxWidth = $clog2(MemDepth);
  localparam int unsigned CntWidth = $clog2(BufDepth + 1);

  logic [DataWidth-1:0] mem [MemDepth];
  rd_stream_state_e     state;
  logic [AddrWidth-1:0] start_addr;
  logic [AddrWidth-1:0] num_words;
  logic [AddrWidth-1:0] ptr;
  logic [AddrWidth-1:0] cnt;
  logic                 loop;
  logic                 inflight;
  logic [AddrWidth-1:0] rd_addr;
  logic [DataWidth-1:0] rd_data;
  logic [CntWidth-1:0]  buf_count;
  logic                 pop;
  logic                 issue;
  logic                 unused_ld_addr_hi;

  assign unused_ld_addr_hi = ^ld_addr_i[AddrWidth-1:IdxWidth];

  assign pop = rd_acc_valid_o && rd_acc_ready_i;
  // A word popped this cycle frees its slot in time for the read issued now.
  assign issue = (state == STREAM) && en_i && !stop_i &&
                 ((int'(buf_count) + int'(inflight) - int'(pop)) < int'(BufDepth));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(MemDepth); i++) mem[i] <= '0;
    end else if (ld_en_i) begin
      mem[ld_addr_i[IdxWidth-1:0]] <= ld_data_i;
    end
  end

  // Synchronous read: a load to the same index in the issue cycle is not yet visible.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight <= 1'b0;
      rd_addr  <= '0;
      rd_data  <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        rd_addr <= ptr;
        rd_data <= mem[ptr[IdxWidth-1:0]];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      start_addr <= '0;
      num_words  <= '0;
      ptr        <= '0;
      cnt        <= '0;
      loop       <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (stop_i) begin
        state  <= IDLE;
        busy_o <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start_i) begin
              start_addr <= cfg_start_addr_i;
              num_words  <= cfg_num_words_i;
              loop       <= cfg_loop_i;
              ptr        <= cfg_start_addr_i;
              cnt        <= '0;
              if (cfg_num_words_i == '0) begin
                state  <= DONE;
                done_o <= 1'b1;
              end else begin
                state  <= STREAM;
                busy_o <= 1'b1;
              end
            end
          end
          STREAM: begin
            if (issue) begin
              if ((cnt + AddrWidth'(1) == num_words) && loop) begin
                ptr <= start_addr;
                cnt <= '0;
              end else begin
                ptr <= ptr + AddrWidth'(1);
                cnt <= cnt + AddrWidth'(1);
                if (cnt + AddrWidth'(1) == num_words) state <= DRAIN;
              end
            end
          end
          DRAIN: begin
            // Finish on the edge that pops the last buffered word.
            if (!inflight && (buf_count == '0 || (buf_count == CntWidth'(1) && pop))) begin
              state  <= DONE;
              busy_o <= 1'b0;
              done_o <= 1'b1;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  tb_stream_fifo #(
    .Width(AddrWidth + DataWidth),
    .Depth(BufDepth)
  ) u_buf (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .flush  (stop_i),
    .in_vld (inflight),
    .in_dat ({rd_addr, rd_data}),
    .out_vld(rd_acc_valid_o),
    .out_dat({rd_acc_addr_o, rd_acc_data_o}),
    .out_rdy(rd_acc_ready_i),
    .count  (buf_count)
  );

endmodule

// File: tb/tb_tb_rd_stream_memory.sv
// Directed bench for the stream source memory: ordering, backpressure, loop, wrap, load race, reset.
module tb_tb_rd_stream_memory;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        en_i = 1'b1;
  logic        ld_en_i = 1'b0;
  logic [31:0] ld_addr_i = '0;
  logic [31:0] ld_data_i = '0;
  logic [31:0] cfg_start_addr_i = '0;
  logic [31:0] cfg_num_words_i = '0;
  logic        cfg_loop_i = 1'b0;
  logic        start_i = 1'b0;
  logic        stop_i = 1'b0;
  logic [31:0] rd_acc_addr_o;
  logic [31:0] rd_acc_data_o;
  logic        rd_acc_valid_o;
  logic        rd_acc_ready_i = 1'b0;
  logic        busy_o;
  logic        done_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] bd [16];
  logic [31:0] ba [16];
  int nb;

  tb_rd_stream_memory dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i),
    .ld_en_i(ld_en_i), .ld_addr_i(ld_addr_i), .ld_data_i(ld_data_i),
    .cfg_start_addr_i(cfg_start_addr_i), .cfg_num_words_i(cfg_num_words_i),
    .cfg_loop_i(cfg_loop_i), .start_i(start_i), .stop_i(stop_i),
    .rd_acc_addr_o(rd_acc_addr_o), .rd_acc_data_o(rd_acc_data_o),
    .rd_acc_valid_o(rd_acc_valid_o), .rd_acc_ready_i(rd_acc_ready_i),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    ld_en_i = 1'b1; ld_addr_i = a; ld_data_i = d;
    step();
    ld_en_i = 1'b0;
  endtask

  task automatic start(input logic [31:0] sa, input logic [31:0] n, input logic lp);
    cfg_start_addr_i = sa; cfg_num_words_i = n; cfg_loop_i = lp; start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  // Record every handshake until n beats or the cycle budget runs out.
  task automatic run_beats(input int n, input int bound);
    nb = 0;
    for (int c = 0; c < bound && nb < n; c++) begin
      if (rd_acc_valid_o && rd_acc_ready_i) begin
        bd[nb] = rd_acc_data_o;
        ba[nb] = rd_acc_addr_o;
        nb++;
      end
      step();
    end
  endtask

  task automatic wait_done(input string tag, input int bound);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < bound && !seen; c++) begin
      if (done_o) seen = 1'b1;
      else step();
    end
    chk(tag, seen, 1'b1);
  endtask

  initial begin
    logic        stalled;
    logic [31:0] prev_d, prev_a;
    logic        seen_done;

    // Reset state
    #12;
    chk("rst_valid", rd_acc_valid_o, 1'b0);
    chk("rst_data", rd_acc_data_o, 32'h0);
    chk("rst_addr", rd_acc_addr_o, 32'h0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    rst_ni = 1'b1;
    step();

    for (int i = 0; i < 16; i++) load(32'(i), 32'h100 + 32'(i));

    // Full-rate region 4..11
    rd_acc_ready_i = 1'b1;
    start(32'd4, 32'd8, 1'b0);
    chk("t1_busy", busy_o, 1'b1);
    chk("t1_lat0", rd_acc_valid_o, 1'b0);
    step();
    chk("t1_lat1", rd_acc_valid_o, 1'b0);
    step();
    for (int i = 0; i < 8; i++) begin
      chk("t1_valid", rd_acc_valid_o, 1'b1);
      chk("t1_data", rd_acc_data_o, 32'h104 + 32'(i));
      chk("t1_addr", rd_acc_addr_o, 32'd4 + 32'(i));
      chk("t1_nodone", done_o, 1'b0);
      step();
    end
    chk("t1_done", done_o, 1'b1);
    chk("t1_end_valid", rd_acc_valid_o, 1'b0);
    chk("t1_end_busy", busy_o, 1'b0);
    step();
    chk("t1_done_pulse", done_o, 1'b0);

    // Alternating ready
    start(32'd4, 32'd8, 1'b0);
    nb = 0; stalled = 1'b0; seen_done = 1'b0; prev_d = '0; prev_a = '0;
    for (int c = 0; c < 80 && !seen_done; c++) begin
      if (stalled) begin
        chk("t2_hold_valid", rd_acc_valid_o, 1'b1);
        chk("t2_hold_data", rd_acc_data_o, prev_d);
        chk("t2_hold_addr", rd_acc_addr_o, prev_a);
      end
      rd_acc_ready_i = (c % 2 == 0);
      chk("t2_bufmax", 64'(dut.u_buf.count > 2'd2), 64'd0);
      if (rd_acc_valid_o && rd_acc_ready_i) begin
        chk("t2_data", rd_acc_data_o, 32'h104 + 32'(nb));
        chk("t2_addr", rd_acc_addr_o, 32'd4 + 32'(nb));
        nb++;
      end
      stalled = rd_acc_valid_o && !rd_acc_ready_i;
      prev_d = rd_acc_data_o; prev_a = rd_acc_addr_o;
      if (done_o) seen_done = 1'b1;
      else step();
    end
    chk("t2_count", 32'(nb), 32'd8);
    chk("t2_done", seen_done, 1'b1);
    rd_acc_ready_i = 1'b1;
    step();

    // Loop mode, then stop together with start
    start(32'd0, 32'd3, 1'b1);
    run_beats(10, 40);
    chk("t3_count", 32'(nb), 32'd10);
    for (int k = 0; k < 10; k++) begin
      chk("t3_data", bd[k], 32'h100 + 32'(k % 3));
      chk("t3_addr", ba[k], 32'(k % 3));
    end
    stop_i = 1'b1; start_i = 1'b1;
    step();
    stop_i = 1'b0; start_i = 1'b0;
    chk("t3_stop_valid", rd_acc_valid_o, 1'b0);
    chk("t3_stop_busy", busy_o, 1'b0);
    chk("t3_stop_done", done_o, 1'b0);
    step();
    chk("t3_start_ignored", busy_o, 1'b0);
    chk("t3_no_done", done_o, 1'b0);

    // Zero-length region
    start(32'd0, 32'd0, 1'b0);
    chk("t4_done", done_o, 1'b1);
    chk("t4_valid", rd_acc_valid_o, 1'b0);
    chk("t4_busy", busy_o, 1'b0);
    step();
    chk("t4_done_pulse", done_o, 1'b0);
    chk("t4_valid2", rd_acc_valid_o, 1'b0);

    // Wrap around the memory end
    load(32'd1022, 32'hA1);
    load(32'd1023, 32'hA2);
    start(32'd1022, 32'd4, 1'b0);
    run_beats(4, 30);
    chk("t5_count", 32'(nb), 32'd4);
    chk("t5_d0", bd[0], 32'hA1);
    chk("t5_d1", bd[1], 32'hA2);
    chk("t5_d2", bd[2], 32'h100);
    chk("t5_d3", bd[3], 32'h101);
    chk("t5_a2", ba[2], 32'd1024);
    chk("t5_a3", ba[3], 32'd1025);
    wait_done("t5_done", 10);
    step();

    // Load races the first issue of word 5
    start(32'd5, 32'd1, 1'b1);
    load(32'd5, 32'hAA);
    run_beats(2, 20);
    chk("t6_count", 32'(nb), 32'd2);
    chk("t6_old", bd[0], 32'h105);
    chk("t6_new", bd[1], 32'hAA);
    stop_i = 1'b1;
    step();
    stop_i = 1'b0;
    step();

    // Async reset mid-stream
    start(32'd4, 32'd8, 1'b0);
    run_beats(3, 20);
    chk("t7_sent3", 32'(nb), 32'd3);
    chk("t7_pre_valid", rd_acc_valid_o, 1'b1);
    #2 rst_ni = 1'b0;
    #1;
    chk("t7_rst_valid", rd_acc_valid_o, 1'b0);
    chk("t7_rst_data", rd_acc_data_o, 32'h0);
    chk("t7_rst_addr", rd_acc_addr_o, 32'h0);
    chk("t7_rst_busy", busy_o, 1'b0);
    step();
    rst_ni = 1'b1;
    step();
    start(32'd4, 32'd2, 1'b0);
    run_beats(2, 20);
    chk("t7_count", 32'(nb), 32'd2);
    chk("t7_d0", bd[0], 32'h0);
    chk("t7_d1", bd[1], 32'h0);
    chk("t7_a1", ba[1], 32'd5);
    wait_done("t7_done", 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
